// File: rtl/hex_display_mm.sv
// Avalon-MM seven-segment display peripheral: per-digit hex/raw/blink registers,
// global blank and lamp-test, registered segment outputs with selectable polarity.
module hex_display_mm #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic [NUM_DIGITS*7-1:0] hex_export
);

  localparam int unsigned PW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0]  CTRL_ADDR   = 4'd14;
  localparam logic [3:0]  STATUS_ADDR = 4'd15;

  logic [3:0]              nibble   [NUM_DIGITS];
  logic                    raw      [NUM_DIGITS];
  logic [6:0]              raw_segs [NUM_DIGITS];
  logic                    blink_en [NUM_DIGITS];
  logic                    blank_all;
  logic                    lamp_test;
  logic [PW-1:0]           presc;
  logic                    blink_phase;
  logic [NUM_DIGITS*7-1:0] seg_q;
  logic [NUM_DIGITS*7-1:0] seg_d;
  logic [31:0]             rd_mux;
  logic                    unused_wdata;

  assign unused_wdata = ^{avs_writedata[31:17], avs_writedata[15], avs_writedata[7:5]};

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Read mux sees pre-edge register values, so a same-cycle write returns the old data.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (avs_address == 4'(i)) begin
        rd_mux = {15'd0, blink_en[i], 1'b0, raw_segs[i], 3'd0, raw[i], nibble[i]};
      end
    end
    if (avs_address == CTRL_ADDR) begin
      rd_mux = {30'd0, lamp_test, blank_all};
    end
    if (avs_address == STATUS_ADDR) begin
      rd_mux = {16'(NUM_DIGITS), 15'd0, blink_phase};
    end
  end

  always_comb begin
    seg_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (lamp_test) begin
        seg_d[7*i +: 7] = '1;
      end else if (blank_all || (blink_en[i] && blink_phase)) begin
        seg_d[7*i +: 7] = '0;
      end else if (raw[i]) begin
        seg_d[7*i +: 7] = raw_segs[i];
      end else begin
        seg_d[7*i +: 7] = hex_decode(nibble[i]);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        nibble[i]   <= '0;
        raw[i]      <= 1'b0;
        raw_segs[i] <= '0;
        blink_en[i] <= 1'b0;
      end
      blank_all    <= 1'b0;
      lamp_test    <= 1'b0;
      presc        <= '0;
      blink_phase  <= 1'b0;
      avs_readdata <= '0;
      seg_q        <= '0;
    end else begin
      if (presc == PW'(BLINK_DIV - 1)) begin
        presc       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        presc <= presc + 1'b1;
      end

      if (avs_write) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (avs_address == 4'(i)) begin
            nibble[i]   <= avs_writedata[3:0];
            raw[i]      <= avs_writedata[4];
            raw_segs[i] <= avs_writedata[14:8];
            blink_en[i] <= avs_writedata[16];
          end
        end
        if (avs_address == CTRL_ADDR) begin
          blank_all <= avs_writedata[0];
          lamp_test <= avs_writedata[1];
        end
      end

      if (avs_read) begin
        avs_readdata <= rd_mux;
      end

      seg_q <= seg_d;
    end
  end

  assign hex_export = ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_hex_display_mm.sv
// Bench for hex_display_mm: directed vector table, blink/reset sequences and
// randomized bus traffic checked every cycle against a register-level model.
module tb_hex_display_mm;

  localparam int ND  = 6;
  localparam int DIV = 4;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic [3:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [ND*7-1:0] hex_export;

  hex_display_mm #(
    .NUM_DIGITS(ND),
    .BLINK_DIV (DIV),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .hex_export   (hex_export)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register words as the bus sees them, edge count since reset.
  logic [31:0]     m_dig [ND];
  logic [31:0]     m_ctrl;
  int              m_n;
  logic [ND*7-1:0] exp_hex;
  logic [31:0]     exp_rd;

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return g[v];
  endfunction

  function automatic bit m_phase();
    return bit'((m_n / DIV) % 2);
  endfunction

  function automatic logic [ND*7-1:0] m_hex();
    logic [ND*7-1:0] v;
    logic [6:0] s;
    for (int i = 0; i < ND; i++) begin
      if (m_ctrl[1])                         s = 7'h7F;
      else if (m_ctrl[0])                    s = 7'h00;
      else if (m_dig[i][16] && m_phase())    s = 7'h00;
      else if (m_dig[i][4])                  s = m_dig[i][14:8];
      else                                   s = glyph(int'(m_dig[i][3:0]));
      v[7*i +: 7] = ~s;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (int'(a) < ND) return m_dig[a];
    if (a == 4'd14)   return m_ctrl;
    if (a == 4'd15)   return {16'(ND), 15'd0, m_phase()};
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One bus cycle: drive inputs, advance DUT and model one edge, compare everything.
  task automatic step(input bit rst, input bit rd, input bit wr,
                      input logic [3:0] a, input logic [31:0] d);
    logic [ND*7-1:0] pre_hex;
    logic [31:0] pre_rd;
    reset_reset = rst; avs_read = rd; avs_write = wr;
    avs_address = a; avs_writedata = d;
    pre_hex = m_hex();
    pre_rd  = m_read(a);
    @(posedge clk_clk);
    if (rst) begin
      for (int i = 0; i < ND; i++) m_dig[i] = '0;
      m_ctrl = '0; m_n = 0; exp_hex = '1; exp_rd = '0;
    end else begin
      exp_hex = pre_hex;
      if (rd) exp_rd = pre_rd;
      if (wr && int'(a) < ND) m_dig[a] = d & 32'h0001_7F1F;
      if (wr && a == 4'd14)   m_ctrl = d & 32'h3;
      m_n++;
    end
    #1;
    check("model_hex", 64'(hex_export), 64'(exp_hex));
    check("model_rd", 64'(avs_readdata), 64'(exp_rd));
  endtask

  typedef struct {
    bit          rd, wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          dig;      // -1: no segment check
    logic [6:0]  exp_seg;
    logic [31:0] rd_mask;  // 0: no readdata check
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v_wr(input logic [3:0] a, input logic [31:0] d);
    return '{rd: 1'b0, wr: 1'b1, addr: a, data: d, dig: -1, exp_seg: '0, rd_mask: '0, exp_rd: '0};
  endfunction
  function automatic vec_t v_rd(input logic [3:0] a);
    return '{rd: 1'b1, wr: 1'b0, addr: a, data: '0, dig: -1, exp_seg: '0, rd_mask: '0, exp_rd: '0};
  endfunction
  function automatic vec_t v_rw(input logic [3:0] a, input logic [31:0] d);
    return '{rd: 1'b1, wr: 1'b1, addr: a, data: d, dig: -1, exp_seg: '0, rd_mask: '0, exp_rd: '0};
  endfunction
  function automatic vec_t v_chk(input int dg, input logic [6:0] s,
                                 input logic [31:0] m, input logic [31:0] r);
    return '{rd: 1'b0, wr: 1'b0, addr: '0, data: '0, dig: dg, exp_seg: s, rd_mask: m, exp_rd: r};
  endfunction

  initial begin
    int toggles;
    logic [6:0] prev, cur;

    tbl.push_back(v_chk(0, 7'h40, '1, 32'h0));
    tbl.push_back(v_wr(4'd0, 32'h5));
    tbl.push_back(v_chk(0, 7'h12, '0, '0));
    tbl.push_back(v_chk(1, 7'h40, '0, '0));
    tbl.push_back(v_chk(5, 7'h40, '0, '0));
    tbl.push_back(v_wr(4'd1, 32'h5510));
    tbl.push_back(v_chk(1, 7'h2A, '0, '0));
    tbl.push_back(v_wr(4'd1, 32'h000F));
    tbl.push_back(v_chk(1, 7'h0E, '0, '0));
    tbl.push_back(v_wr(4'd14, 32'h3));
    tbl.push_back(v_chk(0, 7'h00, '0, '0));
    tbl.push_back(v_chk(4, 7'h00, '0, '0));
    tbl.push_back(v_wr(4'd14, 32'h1));
    tbl.push_back(v_chk(3, 7'h7F, '0, '0));
    tbl.push_back(v_wr(4'd14, 32'h0));
    tbl.push_back(v_chk(0, 7'h12, '0, '0));
    tbl.push_back(v_rd(4'd0));
    tbl.push_back(v_chk(-1, '0, '1, 32'h5));
    tbl.push_back(v_rd(4'd13));
    tbl.push_back(v_chk(-1, '0, '1, 32'h0));
    tbl.push_back(v_rd(4'd15));
    tbl.push_back(v_chk(-1, '0, 32'hFFFF_0000, 32'h0006_0000));
    tbl.push_back(v_rw(4'd0, 32'h9));
    tbl.push_back(v_chk(0, 7'h10, '1, 32'h5));
    tbl.push_back(v_rd(4'd0));
    tbl.push_back(v_chk(-1, '0, '1, 32'h9));
    tbl.push_back(v_wr(4'd15, 32'hFFFF_FFFF));
    tbl.push_back(v_rd(4'd15));
    tbl.push_back(v_chk(-1, '0, 32'hFFFF_FFFE, 32'h0006_0000));
    tbl.push_back(v_wr(4'd6, 32'h1234));
    tbl.push_back(v_rd(4'd6));
    tbl.push_back(v_chk(-1, '0, '1, 32'h0));
    tbl.push_back(v_wr(4'd14, 32'hFFFF_FFFC));
    tbl.push_back(v_rd(4'd14));
    tbl.push_back(v_chk(-1, '0, '1, 32'h0));

    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    check("reset_hex", 64'(hex_export), 64'({ND*7{1'b1}}));
    check("reset_rd", 64'(avs_readdata), 64'h0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
      if (tbl[i].dig >= 0)
        check($sformatf("tbl_seg[%0d]", i), 64'(hex_export[7*tbl[i].dig +: 7]), 64'(tbl[i].exp_seg));
      if (tbl[i].rd_mask != 0)
        check($sformatf("tbl_rd[%0d]", i), 64'(avs_readdata & tbl[i].rd_mask), 64'(tbl[i].exp_rd));
    end

    // Blink on digit 2 showing "8": segments follow STATUS[0], period DIV.
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'd2, 32'h0001_0008);
    toggles = 0;
    prev = 7'h00;
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd15, 32'h0);
      cur = hex_export[20:14];
      check($sformatf("blink_vs_status[%0d]", k), 64'(cur), 64'(avs_readdata[0] ? 7'h7F : 7'h00));
      if (k > 0 && cur != prev) toggles++;
      prev = cur;
    end
    check("blink_toggles", 64'(toggles), 64'd4);

    // Reset mid-blink with a read and write pending.
    step(1'b1, 1'b1, 1'b1, 4'd0, 32'h5);
    check("midreset_hex", 64'(hex_export), 64'({ND*7{1'b1}}));
    check("midreset_rd", 64'(avs_readdata), 64'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < ND; i++)
      check($sformatf("post_reset_digit[%0d]", i), 64'(hex_export[7*i +: 7]), 64'h40);
    step(1'b0, 1'b1, 1'b0, 4'd15, 32'h0);
    check("post_reset_phase", 64'(avs_readdata[0]), 64'h0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 32'h0);
    check("post_reset_dig0", 64'(avs_readdata), 64'h0);

    // Random traffic, occasional reset.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] d;
      d = $urandom();
      if ($urandom_range(0, 3) != 0) d = d & 32'h0001_7F1C;
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
